// File: rtl/sdc_wb_arb_pkg.sv
// sdc_wb_arb_pkg: shared types and constants for the two-master Wishbone memory arbiter.
// Contents: FSM state enum, Wishbone CTI/BTE codes, default watchdog timeout.
package sdc_wb_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} arb_state_t;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam int DEFAULT_TIMEOUT = 1024;
endpackage

// File: rtl/sdc_wb_arb_watchdog.sv
// sdc_wb_arb_watchdog: counts stalled strobe cycles and emits a one-cycle abort pulse.
// Ports: i_clk/i_rst clock and sync active-high reset; i_active bus granted;
//   i_stb owner strobe before abort masking; i_ack slave ack;
//   o_abort one-cycle abort (err) pulse; o_timeout sticky expiry flag.
module sdc_wb_arb_watchdog
   import sdc_wb_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_active,
   input  logic i_stb,
   input  logic i_ack,
   output logic o_abort,
   output logic o_timeout
);
   localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_count;
   logic        r_abort;
   logic        r_timeout;
   logic        w_stall;
   logic        w_expire;
   // The strobe seen by the slave is masked during the abort cycle, so that cycle never counts.
   assign w_stall  = i_active & i_stb & ~r_abort & ~i_ack;
   assign w_expire = w_stall & (r_count == LP_LAST);
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count   <= 16'd0;
         r_abort   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_count   <= (w_stall & ~w_expire) ? r_count + 16'd1 : 16'd0;
         r_abort   <= w_expire;
         r_timeout <= r_timeout | w_expire;
      end
   end
   assign o_abort   = r_abort;
   assign o_timeout = r_timeout;
endmodule

// File: rtl/sdc_wb_mem_arbiter.sv
// sdc_wb_mem_arbiter: two-master Wishbone B4 arbiter (m0 CPU, m1 SD DMA) onto one memory slave.
// Ports: wb_clk_i/wb_rst_i clock and sync active-high reset; m0_*/m1_* master buses;
//   s_* slave bus; timeout_o sticky watchdog flag.
// Optional watchdog enabled by defining SDC_WB_ARB_TIMEOUT_EN.
module sdc_wb_mem_arbiter
   import sdc_wb_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic [2:0]  m0_cti_i,
   input  logic [1:0]  m0_bte_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic [2:0]  m1_cti_i,
   input  logic [1:0]  m1_bte_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic [2:0]  s_cti_o,
   output logic [1:0]  s_bte_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   output logic        timeout_o
);
   arb_state_t r_state;
   arb_state_t w_next;
   logic       r_last_grant;
   logic       w_stb_raw;
   logic       w_abort;
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_next != IDLE) r_last_grant <= (w_next == GNT1);
      end
   end
   always_comb begin
      w_next    = r_state;
      s_adr_o   = '0;
      s_dat_o   = '0;
      s_sel_o   = '0;
      s_we_o    = 1'b0;
      s_cyc_o   = 1'b0;
      s_cti_o   = '0;
      s_bte_o   = '0;
      w_stb_raw = 1'b0;
      m0_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m1_ack_o  = 1'b0;
      m1_err_o  = 1'b0;
      case (r_state)
         // On a tie the master that did not own the bus last time wins.
         IDLE: w_next = (m0_cyc_i & (~m1_cyc_i | r_last_grant)) ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
         GNT0: begin
            w_next    = m0_cyc_i ? GNT0 : IDLE;
            s_adr_o   = m0_adr_i;
            s_dat_o   = m0_dat_i;
            s_sel_o   = m0_sel_i;
            s_we_o    = m0_we_i;
            s_cyc_o   = m0_cyc_i;
            s_cti_o   = m0_cti_i;
            s_bte_o   = m0_bte_i;
            w_stb_raw = m0_cyc_i & m0_stb_i;
            m0_ack_o  = s_ack_i;
            m0_err_o  = w_abort;
         end
         GNT1: begin
            w_next    = m1_cyc_i ? GNT1 : IDLE;
            s_adr_o   = m1_adr_i;
            s_dat_o   = m1_dat_i;
            s_sel_o   = m1_sel_i;
            s_we_o    = m1_we_i;
            s_cyc_o   = m1_cyc_i;
            s_cti_o   = m1_cti_i;
            s_bte_o   = m1_bte_i;
            w_stb_raw = m1_cyc_i & m1_stb_i;
            m1_ack_o  = s_ack_i;
            m1_err_o  = w_abort;
         end
         default: w_next = IDLE;
      endcase
      s_stb_o = w_stb_raw & ~w_abort;
   end
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
`ifdef SDC_WB_ARB_TIMEOUT_EN
   sdc_wb_arb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clk    (wb_clk_i),
      .i_rst    (wb_rst_i),
      .i_active (r_state != IDLE),
      .i_stb    (w_stb_raw),
      .i_ack    (s_ack_i),
      .o_abort  (w_abort),
      .o_timeout(timeout_o)
   );
`else
   logic w_unused;
   assign w_unused  = |16'(TIMEOUT_CYCLES);
   assign w_abort   = 1'b0;
   assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_sdc_wb_mem_arbiter.sv
// tb_sdc_wb_mem_arbiter: directed stimulus with a transaction-level model checked every cycle.
module tb_sdc_wb_mem_arbiter;
   localparam int T = 16;
   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
   logic [3:0]  m0_sel_i, m1_sel_i;
   logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i, s_ack_i;
   logic [2:0]  m0_cti_i, m1_cti_i;
   logic [1:0]  m0_bte_i, m1_bte_i;
   logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
   logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o, timeout_o;
   logic [2:0]  s_cti_o;
   logic [1:0]  s_bte_o;
   sdc_wb_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .timeout_o(timeout_o)
   );
   always #5 wb_clk_i = ~wb_clk_i;
   int n_vec = 0;
   int n_bad = 0;
   bit check_en = 1'b0;
   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   // Model: who owns the bus (0 none, 1 m0, 2 m1), who owned it last, length of current stall run.
   int m_owner;
   bit m_last;
   int m_stall;
   bit m_errp;
   bit m_tmo;
   logic        e_stb;
   logic [75:0] e_bus;
   logic [4:0]  e_resp;
   always_comb begin
      e_stb = (m_owner == 1) ? (m0_cyc_i & m0_stb_i) : (m_owner == 2) ? (m1_cyc_i & m1_stb_i) : 1'b0;
`ifdef SDC_WB_ARB_TIMEOUT_EN
      e_stb = e_stb & ~m_errp;
`endif
      e_bus = (m_owner == 1) ? {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, e_stb, m0_cti_i, m0_bte_i} :
              (m_owner == 2) ? {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, e_stb, m1_cti_i, m1_bte_i} : '0;
      e_resp = {m_owner == 1 && s_ack_i, m_owner == 2 && s_ack_i, m_owner == 1 && m_errp, m_owner == 2 && m_errp, m_tmo};
   end
   always @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         m_owner <= 0;
         m_last  <= 1'b1;
         m_stall <= 0;
         m_errp  <= 1'b0;
         m_tmo   <= 1'b0;
      end else begin
         m_errp <= 1'b0;
         if (m_owner == 0) begin
            if (m0_cyc_i && (!m1_cyc_i || m_last)) begin
               m_owner <= 1;
               m_last  <= 1'b0;
            end else if (m1_cyc_i) begin
               m_owner <= 2;
               m_last  <= 1'b1;
            end
         end else if (!((m_owner == 1) ? m0_cyc_i : m1_cyc_i)) m_owner <= 0;
`ifdef SDC_WB_ARB_TIMEOUT_EN
         if (e_stb && !s_ack_i) begin
            if (m_stall + 1 == T) begin
               m_errp  <= 1'b1;
               m_tmo   <= 1'b1;
               m_stall <= 0;
            end else m_stall <= m_stall + 1;
         end else m_stall <= 0;
`endif
      end
   end
   always @(negedge wb_clk_i) begin
      if (check_en) begin
         check("slave_bus", {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o}, e_bus);
         check("ack_err_timeout", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o}, e_resp);
         check("read_data", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
      end
   end
   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask
   task automatic idle_all();
      {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i} = '0;
      {m0_cti_i, m1_cti_i, m0_bte_i, m1_bte_i} = '0;
   endtask
   initial begin
      idle_all();
      m0_adr_i = 32'h0; m1_adr_i = 32'h0; m0_dat_i = 32'h1111_0000; m1_dat_i = 32'h2222_0000;
      m0_sel_i = 4'hF; m1_sel_i = 4'hF; s_dat_i = 32'h0;
      tick();
      check_en = 1'b1;
      tick();
      wb_rst_i = 1'b0;
      #3;
      check("reset_cyc", s_cyc_o, 1'b0);
      check("reset_timeout", timeout_o, 1'b0);
      // Solo CPU read
      tick();
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_1000;
      #3 check("solo_pre_grant_stb", s_stb_o, 1'b0);
      tick();
      #3 check("solo_stb", s_stb_o, 1'b1);
      check("solo_adr", s_adr_o, 32'h0000_1000);
      tick();
      s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
      #3 check("solo_ack", m0_ack_o, 1'b1);
      check("solo_dat", m0_dat_o, 32'hDEAD_BEEF);
      check("solo_m1_ack", m1_ack_o, 1'b0);
      tick();
      idle_all();
      #3 check("solo_ack_drop", m0_ack_o, 1'b0);
      // Tie after reset
      tick();
      wb_rst_i = 1;
      tick();
      wb_rst_i = 0;
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100;
      m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h200;
      tick();
      s_ack_i = 1;
      #3 check("tie_first_m0", s_adr_o, 32'h100);
      check("tie_m1_no_ack", m1_ack_o, 1'b0);
      tick();
      s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      #3 check("tie_drop_cyc", s_cyc_o, 1'b0);
      tick();
      #3 check("tie_idle_gap", s_cyc_o, 1'b0);
      tick();
      s_ack_i = 1;
      #3 check("tie_then_m1", s_adr_o, 32'h200);
      check("tie_m1_ack", m1_ack_o, 1'b1);
      check("tie_m0_no_ack", m0_ack_o, 1'b0);
      tick();
      s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      tick();
      m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
      tick();
      #3 check("tie_second_m0", s_adr_o, 32'h100);
      tick();
      idle_all();
      tick();
      tick();
      // No preemption during an m1 burst
      m1_cyc_i = 1; m1_stb_i = 1; m1_cti_i = 3'b010; m1_adr_i = 32'h4000;
      for (int i = 0; i < 8; i++) begin
         tick();
         m1_adr_i = 32'h4000 + 32'(4 * i);
         m1_cti_i = (i == 7) ? 3'b111 : 3'b010;
         m1_dat_i = 32'h2222_0000 + 32'(i);
         s_ack_i = 1; s_dat_i = 32'(i);
         if (i == 2) begin
            m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h1000;
         end
         #3 check("burst_stb", s_stb_o, 1'b1);
         check("burst_adr", s_adr_o, 32'h4000 + 32'(4 * i));
         check("burst_cti", s_cti_o, (i == 7) ? 3'b111 : 3'b010);
      end
      tick();
      m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0; m1_cti_i = 0;
      #3 check("burst_drop_cyc", s_cyc_o, 1'b0);
      tick();
      #3 check("burst_idle_gap", s_cyc_o, 1'b0);
      tick();
      #3 check("burst_m0_grant_cyc", s_cyc_o, 1'b1);
      check("burst_m0_grant_adr", s_adr_o, 32'h1000);
      tick();
      idle_all();
      tick();
      tick();
      // Reset in the middle of an m1 burst
      m1_cyc_i = 1; m1_stb_i = 1; m1_cti_i = 3'b010; m1_adr_i = 32'h8000;
      for (int i = 0; i < 3; i++) begin
         tick();
         m1_adr_i = 32'h8000 + 32'(4 * i);
         s_ack_i = 1;
         if (i == 2) wb_rst_i = 1;
         #3 check("rstburst_beat_cyc", s_cyc_o, 1'b1);
      end
      tick();
      wb_rst_i = 0;
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h1000;
      #3 check("rstburst_cyc_low", s_cyc_o, 1'b0);
      check("rstburst_ack_dropped", m1_ack_o, 1'b0);
      tick();
      s_ack_i = 0;
      #3 check("rstburst_tie_m0", s_adr_o, 32'h1000);
      tick();
      idle_all();
      tick();
      tick();
      // Stalled slave
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h2000;
      for (int i = 1; i <= T + 1; i++) begin
         tick();
         #3;
         if (i <= T) begin
            check("wd_stall_stb", s_stb_o, 1'b1);
            check("wd_stall_err", m0_err_o, 1'b0);
         end else begin
`ifdef SDC_WB_ARB_TIMEOUT_EN
            check("wd_err_pulse", m0_err_o, 1'b1);
            check("wd_stb_forced", s_stb_o, 1'b0);
            check("wd_timeout", timeout_o, 1'b1);
`else
            check("wd_off_err", m0_err_o, 1'b0);
            check("wd_off_stb", s_stb_o, 1'b1);
            check("wd_off_timeout", timeout_o, 1'b0);
`endif
         end
      end
      tick();
      idle_all();
      #3 check("wd_err_single", m0_err_o, 1'b0);
      tick();
      wb_rst_i = 1;
      tick();
      wb_rst_i = 0;
      #3 check("wd_timeout_cleared", timeout_o, 1'b0);
      // Ack exactly at the expiry count
      tick();
      m0_cyc_i = 1; m0_stb_i = 1;
      for (int i = 1; i <= T; i++) begin
         tick();
         if (i == T) s_ack_i = 1;
         #3;
      end
      check("expiry_ack", m0_ack_o, 1'b1);
      check("expiry_no_err", m0_err_o, 1'b0);
      tick();
      idle_all();
      #3 check("expiry_after_err", m0_err_o, 1'b0);
      check("expiry_no_timeout", timeout_o, 1'b0);
      tick();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
